// File: rtl/param_up_dn_counter.sv
// Bounded up/down counter with load clamping, saturate-or-wrap mode and a wrap pulse.
// Define UPDN_STICKY_FLAGS_EN to add sticky overflow/underflow flags (clr_flags, ovf, unf).
module param_up_dn_counter #(
    parameter int              WIDTH   = 5,
    parameter longint unsigned MIN_VAL = 0,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IN,
    input  logic             Load,
    input  logic             Up,
    input  logic             Down,
    input  logic             en,
    input  logic             wrap,
    output logic [WIDTH-1:0] counter,
    output logic             High,
    output logic             Low,
    output logic             wrap_evt
`ifdef UPDN_STICKY_FLAGS_EN
    ,
    input  logic             clr_flags,
    output logic             ovf,
    output logic             unf
`endif
);

    // Bound checks run one bit wider so counter+STEP cannot overflow; results
    // that are guaranteed in range are formed modulo 2**WIDTH.
    localparam logic [WIDTH:0]   MAXX  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEPX = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LIMX  = (WIDTH+1)'(MIN_VAL + STEP);
    localparam logic [WIDTH-1:0] MINW  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAXW  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEPW = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RMSW  = WIDTH'(MAX_VAL - MIN_VAL + 1 - STEP);

    logic [WIDTH:0]   up_sum;
    logic             up_over;
    logic             dn_under;
    logic             do_up;
    logic             do_dn;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wevt_nxt;

    assign up_sum   = {1'b0, counter} + STEPX;
    assign up_over  = up_sum > MAXX;
    assign dn_under = {1'b0, counter} < LIMX;

    always_comb begin
        cnt_nxt  = counter;
        wevt_nxt = 1'b0;
        do_up    = 1'b0;
        do_dn    = 1'b0;
        if (Load) begin
            if (IN < MINW)
                cnt_nxt = MINW;
            else if (IN > MAXW)
                cnt_nxt = MAXW;
            else
                cnt_nxt = IN;
        end else if (en && Down) begin
            do_dn = 1'b1;
            if (!dn_under) begin
                cnt_nxt = counter - STEPW;
            end else if (wrap) begin
                cnt_nxt  = counter + RMSW;
                wevt_nxt = 1'b1;
            end else begin
                cnt_nxt = MINW;
            end
        end else if (en && Up) begin
            do_up = 1'b1;
            if (!up_over) begin
                cnt_nxt = up_sum[WIDTH-1:0];
            end else if (wrap) begin
                // counter + STEP - R, written so no intermediate leaves WIDTH bits
                cnt_nxt  = counter - RMSW;
                wevt_nxt = 1'b1;
            end else begin
                cnt_nxt = MAXW;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter  <= MINW;
            wrap_evt <= 1'b0;
        end else begin
            counter  <= cnt_nxt;
            wrap_evt <= wevt_nxt;
        end
    end

    assign High = (counter == MAXW);
    assign Low  = (counter == MINW);

`ifdef UPDN_STICKY_FLAGS_EN
    // A new overflow/underflow in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= (do_up && up_over)  || (ovf && !clr_flags);
            unf <= (do_dn && dn_under) || (unf && !clr_flags);
        end
    end
`else
    logic unused_dir;
    assign unused_dir = do_up ^ do_dn;
`endif

endmodule

// File: tb/tb_param_up_dn_counter.sv
// Directed bench: default-parameter counter plus a MIN=3/MAX=20/STEP=4 instance.
module tb_param_up_dn_counter;

    logic       clk, rst;
    logic [4:0] in_a, cnt_a, in_b, cnt_b;
    logic       ld_a, up_a, dn_a, en_a, wr_a, hi_a, lo_a, we_a;
    logic       ld_b, up_b, dn_b, en_b, wr_b, hi_b, lo_b, we_b;
`ifdef UPDN_STICKY_FLAGS_EN
    logic       clr_a, ovf_a, unf_a, clr_b, ovf_b, unf_b;
`endif
    int n_chk = 0;
    int n_bad = 0;
    logic saw_we;

    param_up_dn_counter #(.WIDTH(5)) u_a (
        .clk(clk), .rst(rst), .IN(in_a), .Load(ld_a), .Up(up_a), .Down(dn_a),
        .en(en_a), .wrap(wr_a), .counter(cnt_a), .High(hi_a), .Low(lo_a),
        .wrap_evt(we_a)
`ifdef UPDN_STICKY_FLAGS_EN
        , .clr_flags(clr_a), .ovf(ovf_a), .unf(unf_a)
`endif
    );

    param_up_dn_counter #(.WIDTH(5), .MIN_VAL(3), .MAX_VAL(20), .STEP(4)) u_b (
        .clk(clk), .rst(rst), .IN(in_b), .Load(ld_b), .Up(up_b), .Down(dn_b),
        .en(en_b), .wrap(wr_b), .counter(cnt_b), .High(hi_b), .Low(lo_b),
        .wrap_evt(we_b)
`ifdef UPDN_STICKY_FLAGS_EN
        , .clr_flags(clr_b), .ovf(ovf_b), .unf(unf_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {in_a, ld_a, up_a, dn_a, en_a, wr_a} = '0;
        {in_b, ld_b, up_b, dn_b, en_b, wr_b} = '0;
`ifdef UPDN_STICKY_FLAGS_EN
        clr_a = 1'b0; clr_b = 1'b0;
`endif
        #2;
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_we_a", 32'(we_a), 0);
        chk("rst_low_a", 32'(lo_a), 1);
        chk("rst_high_a", 32'(hi_a), 0);
        chk("rst_cnt_b", 32'(cnt_b), 3);
`ifdef UPDN_STICKY_FLAGS_EN
        chk("rst_ovf_a", 32'(ovf_a), 0);
        chk("rst_unf_a", 32'(unf_a), 0);
`endif
        tick(); tick();
        rst = 1'b0;

        // count up saturating: 1..31 then hold
        en_a = 1; up_a = 1; wr_a = 0;
        saw_we = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("sat_up", 32'(cnt_a), (i > 31) ? 31 : i);
            saw_we |= we_a;
        end
        chk("sat_up_noevt", 32'(saw_we), 0);
        chk("sat_up_high", 32'(hi_a), 1);

        // load 1, wrap down 1,0,31,30
        ld_a = 1; in_a = 5'd1; tick();
        chk("ld1", 32'(cnt_a), 1);
        ld_a = 0; up_a = 0; dn_a = 1; wr_a = 1;
        tick(); chk("wdn0", 32'(cnt_a), 0); chk("wdn0_we", 32'(we_a), 0); chk("wdn0_low", 32'(lo_a), 1);
        tick(); chk("wdn31", 32'(cnt_a), 31); chk("wdn31_we", 32'(we_a), 1);
        tick(); chk("wdn30", 32'(cnt_a), 30); chk("wdn30_we", 32'(we_a), 0);

        // priority Load > Down > Up
        ld_a = 1; up_a = 1; dn_a = 1; in_a = 5'd7; tick();
        chk("prio_ld", 32'(cnt_a), 7);
        ld_a = 0; tick();
        chk("prio_dn", 32'(cnt_a), 6);
        en_a = 0; tick();
        chk("en_hold", 32'(cnt_a), 6);

        // wrap up 31 -> 0, then plain step
        en_a = 1; dn_a = 0; up_a = 1; wr_a = 1; ld_a = 1; in_a = 5'd31; tick();
        chk("ld31_we", 32'(we_a), 0);
        ld_a = 0; tick();
        chk("wup0", 32'(cnt_a), 0); chk("wup0_we", 32'(we_a), 1);
        tick();
        chk("wup1", 32'(cnt_a), 1); chk("wup1_we", 32'(we_a), 0);

        // saturate down then switch mode mid-count
        up_a = 0; dn_a = 1; wr_a = 0;
        tick(); chk("sdn0", 32'(cnt_a), 0);
        tick(); chk("sdn_hold", 32'(cnt_a), 0); chk("sdn_hold_we", 32'(we_a), 0);
        wr_a = 1; tick();
        chk("mode_sw", 32'(cnt_a), 31); chk("mode_sw_we", 32'(we_a), 1);

        // async reset mid-cycle, and reset beating Load
        dn_a = 0; up_a = 1; wr_a = 0; ld_a = 1; in_a = 5'd5; tick();
        ld_a = 0; tick();
        chk("pre_rst", 32'(cnt_a), 6);
        #3 rst = 1'b1;
        #1;
        chk("async_rst", 32'(cnt_a), 0);
        chk("async_rst_low", 32'(lo_a), 1);
        ld_a = 1; in_a = 5'd9; tick();
        chk("rst_vs_ld", 32'(cnt_a), 0);
        rst = 1'b0; ld_a = 0; tick();
        chk("post_rst", 32'(cnt_a), 1);

        // offset bounds, STEP=4
        en_a = 0; up_a = 0;
        ld_b = 1; in_b = 5'd25; tick();
        chk("b_ld25", 32'(cnt_b), 20); chk("b_ld25_high", 32'(hi_b), 1);
        ld_b = 0; en_b = 1; up_b = 1; wr_b = 1; tick();
        chk("b_wup6", 32'(cnt_b), 6); chk("b_wup6_we", 32'(we_b), 1);
        ld_b = 1; in_b = 5'd5; tick();
        chk("b_ld5", 32'(cnt_b), 5); chk("b_ld5_we", 32'(we_b), 0);
        ld_b = 0; up_b = 0; dn_b = 1; wr_b = 0; tick();
        chk("b_sdn3", 32'(cnt_b), 3);
        ld_b = 1; in_b = 5'd1; tick();
        chk("b_ld1", 32'(cnt_b), 3); chk("b_ld1_low", 32'(lo_b), 1);
        ld_b = 0; wr_b = 1; tick();
        chk("b_wdn17", 32'(cnt_b), 17); chk("b_wdn17_we", 32'(we_b), 1);
        ld_b = 1; in_b = 5'd18; tick();
        ld_b = 0; dn_b = 0; up_b = 1; wr_b = 0; tick();
        chk("b_sup20", 32'(cnt_b), 20);
        tick();
        chk("b_sup_hold", 32'(cnt_b), 20); chk("b_sup_we", 32'(we_b), 0);

`ifdef UPDN_STICKY_FLAGS_EN
        en_b = 0;
        clr_a = 1; tick();
        chk("clr_ovf", 32'(ovf_a), 0);
        clr_a = 0; ld_a = 1; in_a = 5'd31; tick();
        ld_a = 0; en_a = 1; up_a = 1; dn_a = 0; wr_a = 0; tick();
        chk("ovf_set", 32'(ovf_a), 1);
        up_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ovf_held", 32'(ovf_a), 1);
        end
        up_a = 1; clr_a = 1; tick();
        chk("ovf_set_beats_clr", 32'(ovf_a), 1);
        up_a = 0; tick();
        chk("ovf_cleared", 32'(ovf_a), 0);
        clr_a = 0; ld_a = 1; in_a = 5'd0; tick();
        ld_a = 0; dn_a = 1; tick();
        chk("unf_set", 32'(unf_a), 1);
        chk("unf_cnt", 32'(cnt_a), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/param_up_dn_counter.md
PARAM_UP_DN_COUNTER -- requirements
Module: param_up_dn_counter

Interface
REQ-001 Parameter WIDTH, 5, counter width in bits (2..32).
REQ-002 Parameter MIN_VAL, 0, lower count bound.
REQ-003 Parameter MAX_VAL, 2**WIDTH-1, upper count bound; MIN_VAL < MAX_VAL <= 2**WIDTH-1.
REQ-004 Parameter STEP, 1, increment/decrement magnitude; 1 <= STEP <= MAX_VAL-MIN_VAL+1.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 IN  input  WIDTH  load value.
REQ-008 Load  input  1  synchronous load request.
REQ-009 Up  input  1  count-up request.
REQ-010 Down  input  1  count-down request.
REQ-011 en  input  1  count enable; gates Up/Down only, not Load.
REQ-012 wrap  input  1  mode: 0 = saturate at bounds, 1 = wrap modulo range.
REQ-013 counter  output  WIDTH  registered count.
REQ-014 High  output  1  combinational, counter == MAX_VAL.
REQ-015 Low  output  1  combinational, counter == MIN_VAL.
REQ-016 wrap_evt  output  1  registered one-cycle pulse, set in the cycle after a wrap.

Function
REQ-017 Priority per cycle SHALL be Load > Down > Up; Down and Up together with en=1 SHALL execute Down.
REQ-018 Load SHALL set counter to IN clamped into [MIN_VAL, MAX_VAL]; wrap_evt SHALL be 0 next cycle.
REQ-019 With en=0 and Load=0, counter SHALL hold regardless of Up/Down.
REQ-020 Arithmetic SHALL use WIDTH+1 bits so counter+STEP never overflows internally; R = MAX_VAL-MIN_VAL+1.
REQ-021 Saturate Up: counter+STEP > MAX_VAL -> counter = MAX_VAL; at MAX_VAL (High=1) counter SHALL hold.
REQ-022 Saturate Down: counter-STEP < MIN_VAL -> counter = MIN_VAL; at MIN_VAL (Low=1) counter SHALL hold.
REQ-023 Wrap Up: counter+STEP > MAX_VAL -> counter = counter+STEP-R, wrap_evt=1 next cycle.
REQ-024 Wrap Down: counter-STEP < MIN_VAL -> counter = counter-STEP+R, wrap_evt=1 next cycle.
REQ-025 Counter values outside [MIN_VAL, MAX_VAL] SHALL never be produced after reset.
REQ-026 wrap change mid-count SHALL take effect on the same edge it is sampled; no state is tied to mode.
REQ-027 wrap_evt SHALL be 1 for exactly one cycle per wrap; back-to-back wraps give consecutive pulses.

Reset
REQ-028 rst=1 SHALL immediately force counter=MIN_VAL, wrap_evt=0 (and ovf/unf=0 when built), independent of clk.
REQ-029 Release of rst SHALL be followed by normal operation from the first rising clk edge with rst=0.
REQ-030 Reset asserted mid-count or coincident with Load SHALL win; Load is ignored.

Configuration
REQ-031 Macro UPDN_STICKY_FLAGS_EN SHALL add ports clr_flags (input, 1), ovf (output, 1), unf (output, 1).
REQ-032 With UPDN_STICKY_FLAGS_EN: ovf sets on any Up overflow (clamped or wrapped), unf on any Down underflow; both hold until clr_flags=1 or rst; set beats clr in the same cycle.
REQ-033 Without UPDN_STICKY_FLAGS_EN: the three ports and their registers SHALL be absent; all other behaviour identical.

Verification
REQ-034 Defaults, rst, en=1 Up=1 wrap=0 for 40 cycles -> counter 0..31 then holds 31, High=1, wrap_evt never 1.
REQ-035 Defaults, Load IN=1 then Down=1 wrap=1 -> counter 1,0,31,30; wrap_evt=1 only in cycle after 0->31.
REQ-036 Up=1 Down=1 Load=1 IN=7 same cycle -> counter=7; next cycle Up=Down=1 -> counter=6.
REQ-037 MIN_VAL=3 MAX_VAL=20 STEP=4: Load IN=25 -> 20; Up wrap=1 -> 6 with wrap_evt; Down wrap=0 from 5 -> 3; Load IN=1 -> 3.
REQ-038 rst pulsed between clk edges during counting -> counter=MIN_VAL immediately, before the next edge.
REQ-039 With UPDN_STICKY_FLAGS_EN: saturating Up at 31 -> ovf=1 held 10 cycles; clr_flags=1 with concurrent overflow -> ovf stays 1.
